// File: rtl/spell_rambus_bridge_pkg.sv
// Shared definitions for the spell_rambus bridge: FSM state encoding and
// wishbone byte-lane helpers. Optional line buffer: SPELL_RAMBUS_CACHE_EN.
package spell_rambus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_t;

  localparam int TAG_W = 6;

  // One-hot wishbone select for a byte lane
  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Extract the byte of a 32-bit word on the given lane
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] res;
    case (lane)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      2'd3:    res = word[31:24];
      default: res = word[7:0];
    endcase
    return res;
  endfunction

  // Replace one byte lane of a word, keeping the others
  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      2'd3:    res[31:24] = b;
      default: res[7:0]   = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spell_rambus_bridge_linebuf.sv
// One-word read line buffer (valid, 6-bit word tag, 32-bit data) for the
// spell_rambus bridge. Only present when SPELL_RAMBUS_CACHE_EN is defined.
`ifdef SPELL_RAMBUS_CACHE_EN
module spell_rambus_bridge_linebuf
  import spell_rambus_bridge_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             invalidate,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic [1:0]       lookup_lane,
  output logic             hit,
  output logic [7:0]       hit_byte,
  input  logic             fill_en,
  input  logic             merge_en,
  input  logic             kill_en,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [1:0]       req_lane,
  input  logic [7:0]       req_byte,
  input  logic [31:0]      fill_word
);

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      word;
  logic             tag_match;

  assign tag_match = valid && (tag == req_tag);
  assign hit       = valid && (tag == lookup_tag);
  assign hit_byte  = lane_byte(word, lookup_lane);

  // Buffer update: invalidate beats a same-cycle fill; writes merge only on a tag match
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= 32'h0000_0000;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= req_tag;
      word  <= fill_word;
    end else if (merge_en && tag_match) begin
      word <= merge_byte(word, req_lane, req_byte);
    end else if (kill_en && tag_match) begin
      valid <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/spell_rambus_bridge.sv
// Byte-wide spell memory port bridged to a 32-bit wishbone master.
// Each accepted request becomes one single-word wishbone cycle (or a line
// buffer hit) and one data_ready pulse; a stuck slave is aborted after
// TIMEOUT_CYCLES. Define SPELL_RAMBUS_CACHE_EN to include the line buffer.
module spell_rambus_bridge
  import spell_rambus_bridge_pkg::*;
#(
  parameter logic [7:0] ADDR_BASE      = 8'h00,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        select,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        write,
  input  logic        invalidate,
  input  logic        clear_error,
  output logic [7:0]  data_out,
  output logic        data_ready,
  output logic        bus_error,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  output logic [7:0]  wb_addr_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  bridge_state_t    state;
  logic             armed;
  logic [7:0]       to_cnt;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_lane;
  logic [7:0]       req_byte;
  logic             req_write;
  logic             hit;
  logic [7:0]       hit_byte;
  logic             ack_seen;
  logic             timed_out;

  assign ack_seen  = (state == ST_BUS) && wb_ack_i;
  assign timed_out = (state == ST_BUS) && !wb_ack_i && (TIMEOUT_CYCLES != 8'd0) &&
                     (to_cnt == (TIMEOUT_CYCLES - 8'd1));

`ifdef SPELL_RAMBUS_CACHE_EN
  logic fill_en;
  logic merge_en;
  logic kill_en;

  assign fill_en  = ack_seen && !req_write;
  assign merge_en = ack_seen && req_write;
  assign kill_en  = timed_out && req_write;

  spell_rambus_bridge_linebuf u_linebuf (
    .clock       (clock),
    .reset_n     (reset_n),
    .invalidate  (invalidate),
    .lookup_tag  (addr[7:2]),
    .lookup_lane (addr[1:0]),
    .hit         (hit),
    .hit_byte    (hit_byte),
    .fill_en     (fill_en),
    .merge_en    (merge_en),
    .kill_en     (kill_en),
    .req_tag     (req_tag),
    .req_lane    (req_lane),
    .req_byte    (req_byte),
    .fill_word   (wb_dat_i)
  );
`else
  logic unused_nocache;

  assign hit            = 1'b0;
  assign hit_byte       = 8'h00;
  assign unused_nocache = ^{invalidate, req_tag, req_byte};
`endif

  // Request FSM with registered wishbone and response outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      armed      <= 1'b1;
      to_cnt     <= 8'd0;
      req_tag    <= '0;
      req_lane   <= 2'd0;
      req_byte   <= 8'h00;
      req_write  <= 1'b0;
      data_out   <= 8'h00;
      data_ready <= 1'b0;
      bus_error  <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= 4'b0000;
      wb_dat_o   <= 32'h0000_0000;
      wb_addr_o  <= 8'h00;
    end else begin
      // a timeout below overrides a simultaneous clear
      if (clear_error) begin
        bus_error <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          data_ready <= 1'b0;
          if (!select) begin
            armed <= 1'b1;
          end else if (armed) begin
            req_tag   <= addr[7:2];
            req_lane  <= addr[1:0];
            req_byte  <= data_in;
            req_write <= write;
            if (!write && hit) begin
              data_out   <= hit_byte;
              data_ready <= 1'b1;
              state      <= ST_RESP;
            end else begin
              wb_cyc_o  <= 1'b1;
              wb_stb_o  <= 1'b1;
              wb_we_o   <= write;
              wb_sel_o  <= lane_sel(addr[1:0]);
              wb_addr_o <= ADDR_BASE + {2'b00, addr[7:2]};
              wb_dat_o  <= {4{data_in}};
              to_cnt    <= 8'd0;
              state     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            if (!req_write) begin
              data_out <= lane_byte(wb_dat_i, req_lane);
            end
            data_ready <= 1'b1;
            state      <= ST_RESP;
          end else if (timed_out) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            data_out   <= 8'hFF;
            bus_error  <= 1'b1;
            data_ready <= 1'b1;
            state      <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          data_ready <= 1'b0;
          armed      <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          data_ready <= 1'b0;
          wb_cyc_o   <= 1'b0;
          wb_stb_o   <= 1'b0;
          wb_we_o    <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spell_rambus_bridge.sv
// Directed bench for spell_rambus_bridge (either build of SPELL_RAMBUS_CACHE_EN).
// A table of single requests plus hand-written sequences for hold-off,
// timeout, invalidate-vs-fill, stray ack and reset in the middle of a cycle.
module tb_spell_rambus_bridge;

`ifdef SPELL_RAMBUS_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        select = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic        write = 1'b0;
  logic        invalidate = 1'b0;
  logic        clear_error = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [7:0]  data_out;
  logic        data_ready, bus_error, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [7:0]  wb_addr_o;
  // second instance with a high base to exercise address wrap
  logic [7:0]  d2_data_out, d2_wb_addr_o;
  logic        d2_data_ready, d2_bus_error, d2_cyc, d2_stb, d2_we;
  logic [3:0]  d2_sel;
  logic [31:0] d2_dat;

  always #5 clock = ~clock;

  spell_rambus_bridge #(.ADDR_BASE(8'h00), .TIMEOUT_CYCLES(8'd4)) dut (
    .clock(clock), .reset_n(reset_n), .select(select), .addr(addr), .data_in(data_in),
    .write(write), .invalidate(invalidate), .clear_error(clear_error),
    .data_out(data_out), .data_ready(data_ready), .bus_error(bus_error),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i));

  spell_rambus_bridge #(.ADDR_BASE(8'hF0), .TIMEOUT_CYCLES(8'd4)) dut2 (
    .clock(clock), .reset_n(reset_n), .select(select), .addr(addr), .data_in(data_in),
    .write(write), .invalidate(invalidate), .clear_error(clear_error),
    .data_out(d2_data_out), .data_ready(d2_data_ready), .bus_error(d2_bus_error),
    .wb_cyc_o(d2_cyc), .wb_stb_o(d2_stb), .wb_we_o(d2_we), .wb_sel_o(d2_sel),
    .wb_dat_o(d2_dat), .wb_addr_o(d2_wb_addr_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i));

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  d;
    int          waits;
    logic [31:0] rdata;
    bit          hit;     // hits the line buffer in the cache build
    logic [3:0]  sel;
    logic [7:0]  waddr;
    logic [7:0]  dout;
    logic [31:0] wdat;
  } vec_t;

  vec_t vecs[12];
  int   n_vec = 0;
  int   n_bad = 0;

  bit          bus_seen;
  int          cyc_cnt, lat;
  logic [3:0]  sel_got;
  logic [7:0]  waddr_got, dout_got;
  logic [31:0] wdat_got;
  logic        we_got, err_got;
  bit          exp_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request with a scripted slave; returns what the bus and response looked like
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [31:0] rdata, input bit noack,
                        input bit inv_ack, input int hold,
                        output bit o_bus, output int o_cyc, output logic [3:0] o_sel,
                        output logic [7:0] o_waddr, output logic [31:0] o_wdat,
                        output logic o_we, output logic [7:0] o_dout, output logic o_err,
                        output int o_lat);
    bit         done;
    int         wc;
    logic [7:0] wrap_exp;
    o_bus = 1'b0; o_cyc = 0; o_sel = 4'h0; o_waddr = 8'h00; o_wdat = 32'h0;
    o_we = 1'b0; o_dout = 8'h00; o_err = 1'b0; o_lat = -1; done = 1'b0; wc = 0;
    wrap_exp = 8'hF0 + {2'b00, a[7:2]};
    @(negedge clock);
    select = 1'b1; addr = a; data_in = d; write = wr;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      wb_ack_i = 1'b0;
      invalidate = 1'b0;
      if (data_ready) begin
        done = 1'b1; o_lat = i; o_dout = data_out; o_err = bus_error;
        break;
      end
      if (wb_cyc_o) begin
        if (!o_bus) begin
          o_bus = 1'b1; o_sel = wb_sel_o; o_waddr = wb_addr_o; o_wdat = wb_dat_o; o_we = wb_we_o;
          check("stb_with_cyc", {31'd0, wb_stb_o}, 32'd1);
          check("addr_wrap", {24'd0, d2_wb_addr_o}, {24'd0, wrap_exp});
        end
        o_cyc++;
        if (!noack && wc == waits) begin
          wb_ack_i = 1'b1; wb_dat_i = rdata; invalidate = inv_ack;
        end
        wc++;
      end
    end
    check("ready_seen", {31'd0, done}, 32'd1);
    check("cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_quiet", {30'd0, wb_cyc_o, data_ready}, 32'd0);
    end
    select = 1'b0;
    @(negedge clock);
    check("ready_pulse", {31'd0, data_ready}, 32'd0);
    @(negedge clock);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h05, 8'h00, 2, 32'hDDCCBBAA, 1'b0, 4'b0010, 8'h01, 8'hBB, 32'h0};
    vecs[1]  = '{1'b0, 8'h06, 8'h00, 0, 32'hDDCCBBAA, 1'b1, 4'b0100, 8'h01, 8'hCC, 32'h0};
    vecs[2]  = '{1'b1, 8'h07, 8'h5A, 1, 32'h00000000, 1'b0, 4'b1000, 8'h01, 8'h00, 32'h5A5A5A5A};
    vecs[3]  = '{1'b0, 8'h07, 8'h00, 0, 32'h5ACCBBAA, 1'b1, 4'b1000, 8'h01, 8'h5A, 32'h0};
    vecs[4]  = '{1'b0, 8'h04, 8'h00, 0, 32'h5ACCBBAA, 1'b1, 4'b0001, 8'h01, 8'hAA, 32'h0};
    vecs[5]  = '{1'b0, 8'hFC, 8'h00, 0, 32'h11223344, 1'b0, 4'b0001, 8'h3F, 8'h44, 32'h0};
    vecs[6]  = '{1'b1, 8'h11, 8'h3C, 3, 32'h00000000, 1'b0, 4'b0010, 8'h04, 8'h00, 32'h3C3C3C3C};
    vecs[7]  = '{1'b0, 8'hFD, 8'h00, 0, 32'h11223344, 1'b1, 4'b0010, 8'h3F, 8'h33, 32'h0};
    vecs[8]  = '{1'b0, 8'h10, 8'h00, 1, 32'h0F0E0D0C, 1'b0, 4'b0001, 8'h04, 8'h0C, 32'h0};
    vecs[9]  = '{1'b1, 8'h12, 8'h77, 0, 32'h00000000, 1'b0, 4'b0100, 8'h04, 8'h00, 32'h77777777};
    vecs[10] = '{1'b0, 8'h12, 8'h00, 0, 32'h0F770D0C, 1'b1, 4'b0100, 8'h04, 8'h77, 32'h0};
    vecs[11] = '{1'b0, 8'h13, 8'h00, 2, 32'h0F770D0C, 1'b1, 4'b1000, 8'h04, 8'h0F, 32'h0};

    // reset state
    repeat (2) @(negedge clock);
    check("reset_ctrl", {23'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, data_ready, bus_error}, 32'd0);
    check("reset_dout", {24'd0, data_out}, 32'd0);
    check("reset_waddr", {24'd0, wb_addr_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // table of single requests
    for (int v = 0; v < 12; v++) begin
      do_req(vecs[v].wr, vecs[v].a, vecs[v].d, vecs[v].waits, vecs[v].rdata, 1'b0, 1'b0, 0,
             bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
      exp_bus = !(CACHE && vecs[v].hit);
      check("bus_used", {31'd0, bus_seen}, {31'd0, exp_bus});
      if (exp_bus) begin
        check("wb_sel", {28'd0, sel_got}, {28'd0, vecs[v].sel});
        check("wb_addr", {24'd0, waddr_got}, {24'd0, vecs[v].waddr});
        check("wb_we", {31'd0, we_got}, {31'd0, vecs[v].wr});
        check("cyc_len", cyc_cnt, vecs[v].waits + 1);
        if (vecs[v].wr) check("wb_dat", wdat_got, vecs[v].wdat);
      end else begin
        check("hit_latency", lat, 32'd0);
      end
      if (!vecs[v].wr) check("data_out", {24'd0, dout_got}, {24'd0, vecs[v].dout});
      check("no_error", {31'd0, err_got}, 32'd0);
    end

    // select held 3 cycles past data_ready, then a fresh request is accepted
    do_req(1'b0, 8'h13, 8'h00, 0, 32'h0F770D0C, 1'b0, 1'b0, 3,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("hold_dout", {24'd0, dout_got}, 32'h0F);
    do_req(1'b0, 8'h11, 8'h00, 0, 32'h0F770D0C, 1'b0, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("rearm_dout", {24'd0, dout_got}, 32'h0D);

    // ack while idle is ignored
    @(negedge clock); wb_ack_i = 1'b1;
    @(negedge clock); wb_ack_i = 1'b0;
    check("stray_ack", {30'd0, wb_cyc_o, data_ready}, 32'd0);

    // read timeout, sticky error, clear
    do_req(1'b0, 8'h30, 8'h00, 0, 32'h0, 1'b1, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("to_cyc_len", cyc_cnt, 32'd4);
    check("to_dout", {24'd0, dout_got}, 32'hFF);
    check("to_err", {31'd0, err_got}, 32'd1);
    repeat (3) @(negedge clock);
    check("err_sticky", {31'd0, bus_error}, 32'd1);
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
    check("err_cleared", {31'd0, bus_error}, 32'd0);
    // the timed-out read must not have filled the buffer
    do_req(1'b0, 8'h31, 8'h00, 0, 32'h44332211, 1'b0, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("to_nofill_bus", {31'd0, bus_seen}, 32'd1);
    check("to_nofill_dout", {24'd0, dout_got}, 32'h22);

    // clear_error held through a new timeout: the timeout wins
    clear_error = 1'b1;
    do_req(1'b0, 8'h80, 8'h00, 0, 32'h0, 1'b1, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    clear_error = 1'b0;
    check("clr_vs_to_err", {31'd0, err_got}, 32'd1);

    // write hit that times out drops the buffered word
    do_req(1'b0, 8'h40, 8'h00, 0, 32'hA3A2A1A0, 1'b0, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("fill40_dout", {24'd0, dout_got}, 32'hA0);
    do_req(1'b1, 8'h41, 8'hEE, 0, 32'h0, 1'b1, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("wr_to_err", {31'd0, err_got}, 32'd1);
    do_req(1'b0, 8'h42, 8'h00, 0, 32'hA3A2A1A0, 1'b0, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("wr_to_miss", {31'd0, bus_seen}, 32'd1);
    check("wr_to_dout", {24'd0, dout_got}, 32'hA2);

    // invalidate coincident with the fill ack: next read of that word misses
    do_req(1'b0, 8'h60, 8'h00, 1, 32'h63626160, 1'b0, 1'b1, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("inv_ack_dout", {24'd0, dout_got}, 32'h60);
    do_req(1'b0, 8'h61, 8'h00, 0, 32'h63626160, 1'b0, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("inv_ack_miss", {31'd0, bus_seen}, 32'd1);
    check("inv_ack_dout2", {24'd0, dout_got}, 32'h61);

    // reset in the middle of a bus cycle
    @(negedge clock);
    select = 1'b1; addr = 8'h62; write = 1'b0; data_in = 8'h00;
    @(negedge clock);
    check("mid_bus_cyc", {31'd0, wb_cyc_o}, 32'd1);
    reset_n = 1'b0; select = 1'b0;
    @(negedge clock);
    check("rst_mid_ctrl", {23'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, data_ready, bus_error}, 32'd0);
    check("rst_mid_dout", {24'd0, data_out}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    do_req(1'b0, 8'h62, 8'h00, 0, 32'h63626160, 1'b0, 1'b0, 0,
           bus_seen, cyc_cnt, sel_got, waddr_got, wdat_got, we_got, dout_got, err_got, lat);
    check("rst_miss", {31'd0, bus_seen}, 32'd1);
    check("rst_miss_dout", {24'd0, dout_got}, 32'h62);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
